// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and constants for the vector/DMA sample RAM arbiter
package vec_mem_pkg;

    localparam int LANES  = 16;
    localparam int LANE_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic {
        NORMAL  = 1'b0,
        FORCE_D = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_V    = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    // Who owns the read data coming back next cycle, given this cycle's grants.
    function automatic owner_t read_owner(input logic v_gnt, input logic v_we,
                                          input logic d_gnt, input logic d_we);
        if (v_gnt && !v_we) begin
            return OWN_V;
        end else if (d_gnt && !d_we) begin
            return OWN_D;
        end
        return OWN_NONE;
    endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// rtl/arb_wait_counter.sv - saturating DMA starvation counter with terminal-count flag
module arb_wait_counter
    import vec_mem_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    logic [CNT_W-1:0] wait_cnt;

    // Count consecutive denied DMA cycles; saturate rather than wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != {CNT_W{1'b1}})) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Terminal count: one more conflict at this value earns the DMA a forced slot.
    always_comb begin
        tc = (wait_cnt == CNT_W'(MAX_WAIT - 1));
    end

endmodule

// File: rtl/vec_mem_arbiter.sv
// rtl/vec_mem_arbiter.sv - vector-priority arbiter for sample RAM port B with DMA starvation guard
module vec_mem_arbiter
    import vec_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int DATA_W   = 128,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              v_req,
    input  logic              v_we,
    input  logic [ADDR_W-1:0] v_addr,
    input  logic [DATA_W-1:0] v_wdata,
    output logic              v_stall,
    output logic              v_rvalid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_q
);

    arb_state_t state;
    arb_state_t state_nxt;
    owner_t     rd_owner;
    logic       v_grant;
    logic       d_grant;
    logic       cnt_clr;
    logic       cnt_inc;
    logic       wait_tc;

    arb_wait_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .tc    (wait_tc)
    );

    // Arbitration state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= NORMAL;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants, next state and counter control; the forced slot lasts one cycle,
    // and yields to the vector at once if the DMA has withdrawn its request.
    always_comb begin
        v_grant   = 1'b0;
        d_grant   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        state_nxt = state;
        case (state)
            NORMAL: begin
                if (v_req) begin
                    v_grant = 1'b1;
                end else if (d_req) begin
                    d_grant = 1'b1;
                end
                if (v_req && d_req) begin
                    cnt_inc = 1'b1;
                    if (wait_tc) begin
                        state_nxt = FORCE_D;
                    end
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            FORCE_D: begin
                if (d_req) begin
                    d_grant = 1'b1;
                end else begin
                    v_grant = v_req;
                end
                cnt_clr   = 1'b1;
                state_nxt = NORMAL;
            end
            default: begin
                cnt_clr   = 1'b1;
                state_nxt = NORMAL;
            end
        endcase
    end

    // Port B mux: the DMA drives the RAM only when granted; otherwise the
    // vector address sits on the port and the write enable follows its grant.
    always_comb begin
        mem_addr  = v_addr;
        mem_wdata = v_wdata;
        mem_we    = v_grant & v_we;
        if (d_grant) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
        end
    end

    // Remember who issued this cycle's read so the returning data can be tagged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_owner <= OWN_NONE;
        end else begin
            rd_owner <= read_owner(v_grant, v_we, d_grant, d_we);
        end
    end

    // Requester-facing status and read-return decode.
    always_comb begin
        v_stall  = v_req & ~v_grant;
        d_gnt    = d_grant;
        v_rvalid = (rd_owner == OWN_V);
        d_rvalid = (rd_owner == OWN_D);
        rdata    = mem_q;
    end

endmodule

// File: tb/tb_vec_mem_arbiter.sv
// tb/tb_vec_mem_arbiter.sv - directed scoreboard bench for vec_mem_arbiter
module tb_vec_mem_arbiter;

    localparam int AW = 10;
    localparam int DW = 128;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          v_req, v_we, d_req, d_we;
    logic [AW-1:0] v_addr, d_addr;
    logic [DW-1:0] v_wdata, d_wdata;
    logic          v_stall, v_rvalid, d_gnt, d_rvalid, mem_we;
    logic [DW-1:0] rdata, mem_wdata, mem_q;
    logic [AW-1:0] mem_addr;

    logic [DW-1:0] ram     [0:1023];
    logic [DW-1:0] exp_mem [0:1023];

    typedef struct packed {
        logic          is_d;
        logic [DW-1:0] data;
    } rd_exp_t;

    rd_exp_t sb [$];
    int n_vec = 0;
    int n_err = 0;

    vec_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk       (clk),
        .reset     (reset),
        .v_req     (v_req),
        .v_we      (v_we),
        .v_addr    (v_addr),
        .v_wdata   (v_wdata),
        .v_stall   (v_stall),
        .v_rvalid  (v_rvalid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_q     (mem_q)
    );

    always #5 clk = ~clk;

    // One-cycle-latency RAM port B model.
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_q <= ram[mem_addr];
    end

    function automatic logic [DW-1:0] lanes(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle of requests, queue the expected read return, check the
    // combinational grant/port outputs at the falling edge.
    task automatic step(input logic vr, input logic vw, input logic [AW-1:0] va, input logic [DW-1:0] vd,
                        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd,
                        input logic e_vs, input logic e_dg, input logic e_we, input logic [AW-1:0] e_addr);
        v_req = vr; v_we = vw; v_addr = va; v_wdata = vd;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dd;
        if (e_dg && !dw) sb.push_back('{1'b1, exp_mem[da]});
        else if (!e_dg && vr && !e_vs && !vw) sb.push_back('{1'b0, exp_mem[va]});
        if (e_we) exp_mem[e_addr] = e_dg ? dd : vd;
        @(negedge clk);
        check("v_stall", DW'(v_stall), DW'(e_vs));
        check("d_gnt", DW'(d_gnt), DW'(e_dg));
        check("mem_we", DW'(mem_we), DW'(e_we));
        check("mem_addr", DW'(mem_addr), DW'(e_addr));
        if (e_we) check("mem_wdata", mem_wdata, e_dg ? dd : vd);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, '0, '0, 0, 0, '0, '0, 0, 0, 0, '0);
    endtask

    // Both requesters reading; expectation of which one wins is given.
    task automatic conflict(input logic [AW-1:0] va, input logic [AW-1:0] da, input logic forced);
        step(1, 0, va, '0, 1, 0, da, '0, forced, forced, 0, forced ? da : va);
    endtask

    // Monitor: every read return is matched against the head of the scoreboard.
    initial begin
        rd_exp_t e;
        forever begin
            @(negedge clk);
            if (v_rvalid && d_rvalid) begin
                n_vec++; n_err++;
                $display("FAIL rvalid_exclusive: both v_rvalid and d_rvalid high");
            end else if (v_rvalid || d_rvalid) begin
                if (sb.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL rvalid_unexpected: v_rvalid=%0b d_rvalid=%0b with empty scoreboard", v_rvalid, d_rvalid);
                end else begin
                    e = sb.pop_front();
                    check("rvalid_owner_is_d", DW'(d_rvalid), DW'(e.is_d));
                    check("rdata", rdata, e.data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 1024; i++) begin
            logic [AW-1:0] a;
            a = i[AW-1:0];
            ram[i]     = lanes(a[7:0]);
            exp_mem[i] = lanes(a[7:0]);
        end
        mem_q = '0;
        reset = 1'b0;
        v_req = 0; v_we = 0; v_addr = '0; v_wdata = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_v_rvalid", DW'(v_rvalid), '0);
        check("reset_d_rvalid", DW'(d_rvalid), '0);
        check("reset_d_gnt", DW'(d_gnt), '0);
        check("reset_v_stall", DW'(v_stall), '0);
        check("reset_mem_we", DW'(mem_we), '0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Vector read only.
        step(1, 0, 10'h010, '0, 0, 0, '0, '0, 0, 0, 0, 10'h010);
        idle();

        // DMA write only, then vector read back; vector write and read back.
        step(0, 0, '0, '0, 1, 1, 10'h3FF, lanes(8'hA5), 0, 1, 1, 10'h3FF);
        step(1, 0, 10'h3FF, '0, 0, 0, '0, '0, 0, 0, 0, 10'h3FF);
        step(1, 1, 10'h020, lanes(8'h5A), 0, 0, '0, '0, 0, 0, 1, 10'h020);
        step(1, 0, 10'h020, '0, 0, 0, '0, '0, 0, 0, 0, 10'h020);
        idle();
        check("wb_3ff_model", exp_mem[10'h3FF], lanes(8'hA5));

        // Starvation and alternating V/D reads; count restarts after the forced slot.
        for (int i = 0; i < MW; i++) conflict(10'h001, 10'h002, 0);
        conflict(10'h001, 10'h002, 1);
        for (int i = 0; i < MW; i++) conflict(10'h001, 10'h002, 0);
        conflict(10'h001, 10'h002, 1);
        idle();

        // DMA withdraws in the forced cycle: vector proceeds, counter restarts.
        for (int i = 0; i < MW; i++) conflict(10'h030, 10'h031, 0);
        step(1, 0, 10'h030, '0, 0, 0, 10'h031, '0, 0, 0, 0, 10'h030);
        for (int i = 0; i < MW; i++) conflict(10'h030, 10'h031, 0);
        conflict(10'h030, 10'h031, 1);
        idle();

        // Reset asserted during the forced slot with a vector read in flight.
        for (int i = 0; i < MW; i++) conflict(10'h005, 10'h006, 0);
        check("pre_reset_v_rvalid", DW'(v_rvalid), DW'(1'b1));
        check("pre_reset_d_gnt", DW'(d_gnt), DW'(1'b1));
        #1 reset = 1'b0;
        #1;
        check("mid_reset_v_rvalid", DW'(v_rvalid), '0);
        check("mid_reset_d_rvalid", DW'(d_rvalid), '0);
        check("mid_reset_d_gnt", DW'(d_gnt), '0);
        check("mid_reset_v_stall", DW'(v_stall), '0);
        sb.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        for (int i = 0; i < MW; i++) conflict(10'h005, 10'h006, 0);
        conflict(10'h005, 10'h006, 1);
        idle();
        idle();

        check("scoreboard_drained", DW'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
